// File: rtl/ticket_vending_ctrl.sv
// Ticket vending controller: prices a trip selection, collects coins, dispenses tickets and returns change.
// Define TVC_DENOM_CHECK_EN to accept only 1/5/10/50 coins while paying.
module ticket_vending_ctrl #(
  parameter int unsigned NUM_STATIONS = 8,
  parameter int unsigned STN_W        = 4,
  parameter int unsigned FARE_UNIT    = 5,
  parameter int unsigned MAX_TICKETS  = 15,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned MONEY_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STN_W-1:0]   origin,
  input  logic [STN_W-1:0]   destination,
  input  logic [CNT_W-1:0]   ticket_count,
  input  logic               sel_valid,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_value,
  input  logic               cancel,
  output logic [MONEY_W-1:0] cost_of_ticket,
  output logic [MONEY_W-1:0] money_to_pay,
  output logic [MONEY_W-1:0] total_money,
  output logic               busy,
  output logic               sel_error,
  output logic               coin_reject,
  output logic               dispense_valid,
  output logic [CNT_W-1:0]   tickets_out,
  output logic               change_valid,
  output logic [MONEY_W-1:0] change_amount
);

`ifdef TVC_DENOM_CHECK_EN
  localparam bit DENOM_EN = 1'b1;
`else
  localparam bit DENOM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PAY, DISPENSE, CHANGE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [MONEY_W-1:0] cost_d, due_d, total_d, change_amount_d;
  logic [CNT_W-1:0]   tickets_out_d;
  logic               busy_d, sel_error_d, coin_reject_d, dispense_valid_d, change_valid_d;

  logic               sel_ok, coin_ok, coin_ovf, coin_accept;
  logic [STN_W-1:0]   hops;
  logic [MONEY_W-1:0] price, total_new;
  logic [MONEY_W:0]   coin_sum;

  // Selection validation and pricing (price truncated to MONEY_W)
  assign sel_ok = (32'(origin) < NUM_STATIONS) && (32'(destination) < NUM_STATIONS) &&
                  (origin != destination) && (ticket_count != '0) &&
                  (32'(ticket_count) <= MAX_TICKETS);
  assign hops   = (origin > destination) ? origin - destination : destination - origin;
  assign price  = MONEY_W'(hops) * MONEY_W'(FARE_UNIT) * MONEY_W'(ticket_count);

  // Coin acceptance; the extra sum bit flags wrap-around of the accumulator
`ifdef TVC_DENOM_CHECK_EN
  assign coin_ok = (coin_value == MONEY_W'(1))  || (coin_value == MONEY_W'(5)) ||
                   (coin_value == MONEY_W'(10)) || (coin_value == MONEY_W'(50));
`else
  assign coin_ok = (coin_value != '0);
`endif
  assign coin_sum    = {1'b0, total_money} + {1'b0, coin_value};
  assign coin_ovf    = coin_sum[MONEY_W];
  assign coin_accept = coin_valid && coin_ok && !coin_ovf;
  assign total_new   = coin_accept ? coin_sum[MONEY_W-1:0] : total_money;

  // Next state; pulses are computed on the transition so they align with the new state
  always_comb begin
    state_d          = state;
    count_d          = count_q;
    cost_d           = cost_of_ticket;
    due_d            = money_to_pay;
    total_d          = total_money;
    sel_error_d      = 1'b0;
    coin_reject_d    = 1'b0;
    dispense_valid_d = 1'b0;
    tickets_out_d    = '0;
    change_valid_d   = 1'b0;
    change_amount_d  = '0;

    case (state)
      IDLE: begin
        coin_reject_d = coin_valid;
        if (sel_valid) begin
          if (sel_ok) begin
            state_d = PAY;
            count_d = ticket_count;
            cost_d  = price;
            due_d   = price;
            total_d = '0;
          end else begin
            sel_error_d = 1'b1;
          end
        end
      end
      PAY: begin
        coin_reject_d = coin_valid && (coin_ok ? coin_ovf : DENOM_EN);
        total_d       = total_new;
        due_d         = (total_new >= cost_of_ticket) ? '0 : cost_of_ticket - total_new;
        if (cancel) begin
          state_d         = CHANGE;
          change_valid_d  = 1'b1;
          change_amount_d = total_new;
        end else if (total_new >= cost_of_ticket) begin
          state_d          = DISPENSE;
          dispense_valid_d = 1'b1;
          tickets_out_d    = count_q;
        end
      end
      DISPENSE: begin
        coin_reject_d   = coin_valid;
        state_d         = CHANGE;
        change_valid_d  = 1'b1;
        change_amount_d = total_money - cost_of_ticket;
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        state_d       = IDLE;
        cost_d        = '0;
        due_d         = '0;
        total_d       = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count_q        <= '0;
      cost_of_ticket <= '0;
      money_to_pay   <= '0;
      total_money    <= '0;
      busy           <= 1'b0;
      sel_error      <= 1'b0;
      coin_reject    <= 1'b0;
      dispense_valid <= 1'b0;
      tickets_out    <= '0;
      change_valid   <= 1'b0;
      change_amount  <= '0;
    end else begin
      state          <= state_d;
      count_q        <= count_d;
      cost_of_ticket <= cost_d;
      money_to_pay   <= due_d;
      total_money    <= total_d;
      busy           <= busy_d;
      sel_error      <= sel_error_d;
      coin_reject    <= coin_reject_d;
      dispense_valid <= dispense_valid_d;
      tickets_out    <= tickets_out_d;
      change_valid   <= change_valid_d;
      change_amount  <= change_amount_d;
    end
  end

endmodule

// File: tb/tb_ticket_vending_ctrl.sv
// Self-checking bench for ticket_vending_ctrl: directed scenarios then random traffic,
// all checked against a transaction-level money model.
module tb_ticket_vending_ctrl;
  localparam int unsigned NUM_STATIONS = 8;
  localparam int unsigned STN_W        = 4;
  localparam int unsigned FARE_UNIT    = 5;
  localparam int unsigned MAX_TICKETS  = 15;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned MONEY_W      = 16;
  localparam longint      MONEY_MOD    = longint'(1) << MONEY_W;
`ifdef TVC_DENOM_CHECK_EN
  localparam bit DENOM_EN = 1'b1;
`else
  localparam bit DENOM_EN = 1'b0;
`endif

  logic               clk, reset;
  logic [STN_W-1:0]   origin, destination;
  logic [CNT_W-1:0]   ticket_count;
  logic               sel_valid, coin_valid, cancel;
  logic [MONEY_W-1:0] coin_value;
  logic [MONEY_W-1:0] cost_of_ticket, money_to_pay, total_money, change_amount;
  logic               busy, sel_error, coin_reject, dispense_valid, change_valid;
  logic [CNT_W-1:0]   tickets_out;

  int n_checks = 0;
  int n_fail   = 0;

  ticket_vending_ctrl #(
    .NUM_STATIONS(NUM_STATIONS), .STN_W(STN_W), .FARE_UNIT(FARE_UNIT),
    .MAX_TICKETS(MAX_TICKETS), .CNT_W(CNT_W), .MONEY_W(MONEY_W)
  ) dut (
    .clk(clk), .reset(reset), .origin(origin), .destination(destination),
    .ticket_count(ticket_count), .sel_valid(sel_valid), .coin_valid(coin_valid),
    .coin_value(coin_value), .cancel(cancel), .cost_of_ticket(cost_of_ticket),
    .money_to_pay(money_to_pay), .total_money(total_money), .busy(busy),
    .sel_error(sel_error), .coin_reject(coin_reject), .dispense_valid(dispense_valid),
    .tickets_out(tickets_out), .change_valid(change_valid), .change_amount(change_amount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: phase 0 = no trip, 1 = collecting, 2 = tickets issued, 3 = change returned
  int     phase;
  longint m_cost, m_paid, m_cnt;
  longint e_cost, e_due, e_total, e_busy, e_selerr, e_crej, e_dv, e_tout, e_cv, e_camt;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit denom_ok(input longint v);
    if (DENOM_EN) return (v == 1) || (v == 5) || (v == 10) || (v == 50);
    return v != 0;
  endfunction

  task automatic model_reset();
    phase = 0; m_cost = 0; m_paid = 0; m_cnt = 0;
    e_cost = 0; e_due = 0; e_total = 0; e_busy = 0; e_selerr = 0;
    e_crej = 0; e_dv = 0; e_tout = 0; e_cv = 0; e_camt = 0;
  endtask

  task automatic model_step();
    longint o, d, c, v;
    o = longint'(origin); d = longint'(destination);
    c = longint'(ticket_count); v = longint'(coin_value);
    e_selerr = 0; e_crej = 0; e_dv = 0; e_tout = 0; e_cv = 0; e_camt = 0;
    case (phase)
      0: begin
        if (coin_valid) e_crej = 1;
        if (sel_valid) begin
          if (o < NUM_STATIONS && d < NUM_STATIONS && o != d && c >= 1 && c <= MAX_TICKETS) begin
            m_cost = (((o > d) ? o - d : d - o) * FARE_UNIT * c) % MONEY_MOD;
            m_paid = 0; m_cnt = c; phase = 1;
          end else e_selerr = 1;
        end
      end
      1: begin
        if (coin_valid) begin
          if (!denom_ok(v)) e_crej = (DENOM_EN || v != 0) ? 1 : 0;
          else if (m_paid + v >= MONEY_MOD) e_crej = 1;
          else m_paid = m_paid + v;
        end
        if (cancel) begin
          e_cv = 1; e_camt = m_paid; phase = 3;
        end else if (m_paid >= m_cost) begin
          e_dv = 1; e_tout = m_cnt; phase = 2;
        end
      end
      2: begin
        if (coin_valid) e_crej = 1;
        e_cv = 1; e_camt = m_paid - m_cost; phase = 3;
      end
      default: begin
        if (coin_valid) e_crej = 1;
        m_cost = 0; m_paid = 0; phase = 0;
      end
    endcase
    e_cost  = m_cost;
    e_total = m_paid;
    e_due   = (m_paid >= m_cost) ? 0 : m_cost - m_paid;
    e_busy  = (phase != 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("cost_of_ticket", 64'(cost_of_ticket), e_cost);
    check("money_to_pay",   64'(money_to_pay),   e_due);
    check("total_money",    64'(total_money),    e_total);
    check("busy",           64'(busy),           e_busy);
    check("sel_error",      64'(sel_error),      e_selerr);
    check("coin_reject",    64'(coin_reject),    e_crej);
    check("dispense_valid", 64'(dispense_valid), e_dv);
    check("tickets_out",    64'(tickets_out),    e_tout);
    check("change_valid",   64'(change_valid),   e_cv);
    check("change_amount",  64'(change_amount),  e_camt);
  endtask

  // One clock: model consumes the inputs held across the edge, outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0; coin_value = '0;
  endtask

  task automatic do_sel(input int o, input int d, input int c);
    origin = STN_W'(o); destination = STN_W'(d); ticket_count = CNT_W'(c);
    sel_valid = 1'b1;
    step();
  endtask

  task automatic do_coin(input int v, input bit can);
    coin_valid = 1'b1; coin_value = MONEY_W'(v); cancel = can;
    step();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
  endtask

  int coins[10] = '{0, 1, 5, 7, 10, 25, 50, 100, 65500, 65535};

  initial begin
    reset = 1'b1;
    origin = '0; destination = '0; ticket_count = '0;
    sel_valid = 1'b0; coin_valid = 1'b0; coin_value = '0; cancel = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Basic purchase with change
    do_sel(5, 3, 4);
    check("p1_cost", 64'(cost_of_ticket), 40);
    check("p1_due", 64'(money_to_pay), 40);
    do_coin(5, 1'b0);
    check("p1_total5", 64'(total_money), 5);
    do_coin(10, 1'b0);
    check("p1_due25", 64'(money_to_pay), 25);
    do_coin(50, 1'b0);
    check("p1_dispense", 64'(dispense_valid), 1);
    check("p1_tickets", 64'(tickets_out), 4);
    step();
    check("p1_change", 64'(change_amount), 25);
    step();
    check("p1_idle_total", 64'(total_money), 0);

    // Exact payment: zero change still pulses
    do_sel(3, 4, 2);
    check("p2_cost", 64'(cost_of_ticket), 10);
    do_coin(10, 1'b0);
    step();
    check("p2_change_valid", 64'(change_valid), 1);
    check("p2_change_zero", 64'(change_amount), 0);
    step();

    // Rejected selections
    do_sel(2, 2, 1);
    check("p3_same_stn", 64'(sel_error), 1);
    do_sel(1, 2, 0);
    check("p3_zero_cnt", 64'(sel_error), 1);
    do_sel(8, 1, 1);
    check("p3_bad_origin", 64'(sel_error), 1);
    check("p3_busy", 64'(busy), 0);

    // Cancel with a coin in the same cycle refunds everything
    do_sel(0, 7, 1);
    check("p4_cost", 64'(cost_of_ticket), 35);
    do_coin(10, 1'b0);
    do_coin(5, 1'b1);
    check("p4_refund", 64'(change_amount), 15);
    check("p4_no_dispense", 64'(dispense_valid), 0);
    step();

    // Accumulator overflow
    do_sel(0, 7, 15);
    do_coin(100, 1'b0);
    do_coin(65500, 1'b0);
    check("ovf_reject", 64'(coin_reject), 1);
    do_coin(7, 1'b0);
    do_coin(50, 1'b0);
    do_cancel();
    step();

    // Coin while idle
    do_coin(10, 1'b0);
    check("idle_coin_reject", 64'(coin_reject), 1);

    // Asynchronous reset mid-payment
    do_sel(5, 3, 4);
    do_coin(10, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_busy", 64'(busy), 0);
    #2;
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      sel_valid    = ($urandom_range(0, 99) < 15);
      origin       = STN_W'($urandom_range(0, 9));
      destination  = STN_W'($urandom_range(0, 9));
      ticket_count = CNT_W'($urandom_range(0, 15));
      coin_valid   = ($urandom_range(0, 99) < 45);
      coin_value   = MONEY_W'(coins[$urandom_range(0, 9)]);
      cancel       = ($urandom_range(0, 99) < 6);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ticket_vending_ctrl.md
Name: ticket_vending_ctrl

Overview:
Parametrised ticket vending controller for N stations. It latches a trip selection, prices it, accumulates inserted coins, dispenses tickets, then returns change. It supports cancel/refund, selection validation and overflow-safe money accumulation. It sits between the front-panel input decoder and the ticket/coin-return actuator drivers.

Parameters:
NUM_STATIONS, 8, number of stations; valid station indices are 0..NUM_STATIONS-1
STN_W, 4, station index width
FARE_UNIT, 5, price per hop per ticket
MAX_TICKETS, 15, max tickets per transaction
CNT_W, 4, ticket count width
MONEY_W, 16, width of all money quantities

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
origin  input  STN_W  origin station
destination  input  STN_W  destination station
ticket_count  input  CNT_W  tickets requested
sel_valid  input  1  one-cycle strobe; latch the selection
coin_valid  input  1  one-cycle strobe; coin present
coin_value  input  MONEY_W  value of the coin
cancel  input  1  one-cycle strobe; abort and refund
cost_of_ticket  output  MONEY_W  latched transaction price
money_to_pay  output  MONEY_W  remaining amount due
total_money  output  MONEY_W  money accumulated
busy  output  1  high whenever state != IDLE
sel_error  output  1  one-cycle pulse; selection rejected
coin_reject  output  1  one-cycle pulse; coin not accepted
dispense_valid  output  1  one-cycle pulse; issue tickets
tickets_out  output  CNT_W  tickets to issue; valid with dispense_valid
change_valid  output  1  one-cycle pulse; return change
change_amount  output  MONEY_W  change or refund; valid with change_valid

Behaviour:
- All outputs are registered. On reset, every output is 0 and the state is IDLE. Reset asserted mid-transaction discards held money; no refund pulse is issued.
- States: IDLE, PAY, DISPENSE, CHANGE.
- IDLE, sel_valid:
  - Selection is valid when origin < NUM_STATIONS, destination < NUM_STATIONS, origin != destination, and 1 <= ticket_count <= MAX_TICKETS.
  - Valid: hops = |origin - destination|; cost_of_ticket = hops * FARE_UNIT * ticket_count, truncated to MONEY_W. Latch ticket_count, set money_to_pay = cost_of_ticket and total_money = 0, go to PAY. All of this is visible the cycle after the strobe.
  - Invalid: sel_error pulses 1 cycle; stay in IDLE.
- IDLE, coin_valid: coin_reject pulses. sel_valid outside IDLE is ignored.
- PAY, coin_valid with coin_value != 0:
  - If total_money + coin_value overflows MONEY_W, coin_reject pulses and total is unchanged.
  - Otherwise total_money += coin_value; money_to_pay = saturating (cost - total), floor 0.
  - coin_value == 0 is ignored silently.
- PAY exit:
  - When the updated total >= cost, next state is DISPENSE. The state is DISPENSE the cycle after the qualifying coin.
  - cancel in PAY goes to CHANGE with refund flag set.
  - coin_valid and cancel in the same cycle: the coin is accepted first (same overflow rule), then the refund is taken. The refund includes that coin.
- DISPENSE (1 cycle): dispense_valid=1, tickets_out=latched count; next state CHANGE, refund flag clear.
- CHANGE (1 cycle): change_valid=1. change_amount = total - cost, or total on refund. change_valid pulses even when change_amount=0. Next state IDLE; total_money, money_to_pay and cost_of_ticket clear to 0 on entering IDLE.
- Coins in DISPENSE/CHANGE: coin_reject pulses. cancel in DISPENSE/CHANGE is ignored.
- Latency: paying coin at edge N gives dispense_valid in cycle N+1 and change_valid in cycle N+2.

Optional Feature:
TVC_DENOM_CHECK_EN:
- Defined: in PAY only coin_value in {1, 5, 10, 50} is accepted. Any other value, including 0, pulses coin_reject and leaves total unchanged.
- Undefined: any nonzero value is accepted, subject to the overflow rule.

Test Plan:
1. reset 1 cycle; origin=5, dest=3, count=4, sel_valid -> cost=40, money_to_pay=40, state PAY. Coins 5, 10, 50 -> total 5/15/65, money_to_pay 35/25/0. dispense_valid with tickets_out=4 the cycle after the 50 coin; next cycle change_valid, change_amount=25; then IDLE with totals 0.
2. origin=3, dest=4, count=2 -> cost=10; coin 10 -> dispense, then change_valid with change_amount=0.
3. origin=2, dest=2, count=1 -> sel_error pulse, stays IDLE, cost 0. Repeat with count=0 and with origin=8: each gives sel_error.
4. origin=0, dest=7, count=1 (cost 35); coin 10, then cancel together with coin 5 -> change_valid, change_amount=15, no dispense_valid.
5. MONEY_W=8, cost 200: coins 150 then 150 -> second coin_reject, total stays 150.
6. With TVC_DENOM_CHECK_EN: coin 7 in PAY -> coin_reject, total unchanged; coin 50 accepted. Also coin in IDLE -> coin_reject; reset asserted in PAY -> all outputs 0 asynchronously.
